// File: rtl/out_uart_tx.sv
// rtl/out_uart_tx.sv - core output word FIFO feeding a 2-byte-per-word UART 8N1 transmitter
module out_uart_tx #(
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int CW           = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          out_en,
    input  logic [15:0]   out_dat,
    input  logic          is_halt,
    output logic          txd,
    output logic          busy,
    output logic          overflow,
    output logic          drained,
    output logic [CW-1:0] fifo_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic [1:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [15:0]   shreg;
    logic          byte_sel;
    logic          halt_seen;

    logic          pop;
    logic          push;
    logic          baud_done;
    logic [7:0]    cur_byte;

    // A full FIFO still takes a word in the cycle the transmitter frees a slot.
    assign pop       = (state == S_IDLE) && (fifo_count != '0);
    assign push      = out_en && ((fifo_count != FULL_COUNT) || pop);
    assign baud_done = (baud_cnt == BAUD_LAST);
    assign cur_byte  = byte_sel ? shreg[15:8] : shreg[7:0];
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= out_dat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (out_en && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // txd is loaded with the level of the state being entered, so it is a clean flop output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            byte_sel <= 1'b0;
            txd      <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shreg    <= mem[rd_ptr];
                        byte_sel <= 1'b1;
                        baud_cnt <= '0;
                        state    <= S_START;
                        txd      <= 1'b0;
                    end else begin
                        txd <= 1'b1;
                    end
                end
                S_START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= S_DATA;
                        txd      <= cur_byte[0];
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (byte_sel) begin
                            byte_sel <= 1'b0;
                            state    <= S_START;
                            txd      <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            txd   <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halt_seen <= 1'b0;
            drained   <= 1'b0;
        end else begin
            if (is_halt) begin
                halt_seen <= 1'b1;
            end
            drained <= halt_seen && (fifo_count == '0) && (state == S_IDLE);
        end
    end

endmodule

// File: tb/tb_out_uart_tx.sv
// tb/tb_out_uart_tx.sv - self-checking bench for out_uart_tx
module tb_out_uart_tx;

    localparam int DEPTH = 8;
    localparam int CPB   = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int FRAME = 20 * CPB;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          out_en = 1'b0;
    logic [15:0]   out_dat = 16'h0000;
    logic          is_halt = 1'b0;
    logic          txd;
    logic          busy;
    logic          overflow;
    logic          drained;
    logic [CW-1:0] fifo_count;

    int checks = 0;
    int passes = 0;

    out_uart_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .out_en     (out_en),
        .out_dat    (out_dat),
        .is_halt    (is_halt),
        .txd        (txd),
        .busy       (busy),
        .overflow   (overflow),
        .drained    (drained),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line bit k (0..19) of a word: start, hi byte LSB first, stop, start, lo byte, stop.
    function automatic logic line_bit(input logic [15:0] w, input int k);
        if (k == 0 || k == 10) return 1'b0;
        if (k == 9 || k == 19) return 1'b1;
        if (k < 9) return w[7 + k];
        return w[k - 11];
    endfunction

    // Reference model: a word queue plus the cycle window during which the line is in use.
    logic [15:0] mq[$];
    int          cyc = 0;
    int          busy_until = -1;
    int          pop_t = 0;
    logic [15:0] cur_w = 16'h0000;
    logic        m_ovf = 1'b0;
    logic        m_halt = 1'b0;
    logic        m_drained = 1'b0;

    always @(negedge clk) begin : model
        bit   idle;
        bit   pop_now;
        logic exp_txd;
        int   sz;
        if (!reset) begin
            mq.delete();
            busy_until = -1;
            m_ovf      = 1'b0;
            m_halt     = 1'b0;
            m_drained  = 1'b0;
        end
        idle    = (cyc > busy_until);
        exp_txd = idle ? 1'b1 : line_bit(cur_w, (cyc - pop_t - 1) / CPB);
        chk("m_txd", 32'(txd), 32'(exp_txd));
        chk("m_busy", 32'(busy), 32'(!idle));
        chk("m_count", 32'(fifo_count), 32'(mq.size()));
        chk("m_overflow", 32'(overflow), 32'(m_ovf));
        chk("m_drained", 32'(drained), 32'(m_drained));
        if (reset) begin
            sz        = mq.size();
            pop_now   = idle && (sz > 0);
            m_drained = m_halt && (sz == 0) && idle;
            if (pop_now) begin
                cur_w      = mq.pop_front();
                pop_t      = cyc;
                busy_until = cyc + FRAME;
            end
            if (out_en) begin
                if (sz < DEPTH || pop_now) mq.push_back(out_dat);
                else m_ovf = 1'b1;
            end
            if (is_halt) m_halt = 1'b1;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        out_en  = 1'b1;
        out_dat = d;
        step();
        out_en  = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((busy || fifo_count != '0) && n < limit) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(busy || (fifo_count != '0)), 32'(0));
        step();
        step();
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    typedef struct {
        logic [15:0] dat;
        logic [19:0] bits;
    } vec_t;

    vec_t vt[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{16'hA55A, 20'b0101_0010_1100_1011_0101};
        vt[1] = '{16'h0000, 20'b0000_0000_0100_0000_0001};
        vt[2] = '{16'hFFFF, 20'b0111_1111_1101_1111_1111};
        vt[3] = '{16'h8001, 20'b0000_0000_1101_0000_0001};

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 100; i++) begin
            step();
            chk("t1_txd", 32'(txd), 32'(1));
            chk("t1_busy", 32'(busy), 32'(0));
            chk("t1_count", 32'(fifo_count), 32'(0));
            chk("t1_overflow", 32'(overflow), 32'(0));
        end

        // Abort a frame while a zero bit is on the line.
        send(16'h00FF);
        repeat (30) step();
        chk("t1_txd_midframe", 32'(txd), 32'(0));
        #2 reset = 1'b0;
        #1;
        chk("t1_async_txd", 32'(txd), 32'(1));
        chk("t1_async_busy", 32'(busy), 32'(0));
        chk("t1_async_count", 32'(fifo_count), 32'(0));
        step();
        step();
        reset = 1'b1;
        step();
        chk("t1_restart_idle", 32'(busy), 32'(0));

        for (int v = 0; v < 4; v++) begin
            wait_idle(200);
            send(vt[v].dat);
            chk("tbl_pre_fall", 32'(txd), 32'(1));
            step();
            for (int j = 0; j < FRAME; j++) begin
                if (j == 0) chk("tbl_busy_start", 32'(busy), 32'(1));
                if (j % CPB == 1) chk("tbl_bit", 32'(txd), 32'(vt[v].bits[19 - j / CPB]));
                step();
            end
            chk("tbl_busy_end", 32'(busy), 32'(0));
        end

        wait_idle(200);
        send(16'h1234);
        send(16'hBEEF);
        repeat (79) step();
        chk("t3_stop_lo", 32'(txd), 32'(1));
        step();
        chk("t3_gap_txd", 32'(txd), 32'(1));
        chk("t3_gap_busy", 32'(busy), 32'(0));
        step();
        chk("t3_next_start", 32'(txd), 32'(0));
        chk("t3_next_busy", 32'(busy), 32'(1));

        wait_idle(300);
        for (int i = 0; i < 10; i++) begin
            out_en  = 1'b1;
            out_dat = 16'(i);
            step();
        end
        out_en = 1'b0;
        chk("t4_peak_count", 32'(fifo_count), 32'(DEPTH));
        chk("t4_overflow", 32'(overflow), 32'(1));
        wait_idle(1000);
        chk("t4_overflow_sticky", 32'(overflow), 32'(1));

        pulse_reset();
        chk("t5_overflow_clear", 32'(overflow), 32'(0));
        for (int i = 0; i < 9; i++) send(16'hC000 + 16'(i));
        chk("t5_full", 32'(fifo_count), 32'(DEPTH));
        repeat (72) step();
        chk("t5_last_stop_busy", 32'(busy), 32'(1));
        step();
        chk("t5_pop_cycle_idle", 32'(busy), 32'(0));
        chk("t5_pop_cycle_count", 32'(fifo_count), 32'(DEPTH));
        send(16'hCAFE);
        chk("t5_count_after", 32'(fifo_count), 32'(DEPTH));
        chk("t5_overflow_after", 32'(overflow), 32'(0));
        wait_idle(1200);

        pulse_reset();
        send(16'h1111);
        send(16'h2222);
        send(16'h3333);
        repeat (47) step();
        is_halt = 1'b1;
        step();
        is_halt = 1'b0;
        chk("t6_drained_mid", 32'(drained), 32'(0));
        repeat (193) step();
        chk("t6_last_idle_busy", 32'(busy), 32'(0));
        chk("t6_drained_at_idle", 32'(drained), 32'(0));
        step();
        chk("t6_drained_set", 32'(drained), 32'(1));
        repeat (4) step();
        send(16'h4444);
        chk("t6_drained_hold", 32'(drained), 32'(1));
        step();
        chk("t6_drained_clear", 32'(drained), 32'(0));
        wait_idle(200);
        chk("t6_drained_again", 32'(drained), 32'(1));

        pulse_reset();
        for (int i = 0; i < 3000; i++) begin
            int rate;
            rate    = ((i / 500) % 2 == 1) ? 20 : 1;
            out_en  = ($urandom_range(0, 99) < rate);
            out_dat = 16'($urandom);
            is_halt = ($urandom_range(0, 299) == 0);
            step();
        end
        out_en  = 1'b0;
        is_halt = 1'b0;
        wait_idle(1000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
